// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with synchronous flush; flush overrides push and pop.
module fetch_fifo #(
    parameter int unsigned Width = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: drives A from fetch_pc, buffers {RD, pc} in a 2-entry FIFO,
// supports halt and redirect with flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    RD,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc
);

    localparam int unsigned EntryWidth = DATA_WIDTH + ADDRESS_WIDTH;

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     push, pop;
    logic                     fifo_full, fifo_empty;
    logic [EntryWidth-1:0]    head;
    logic                     unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign A         = fetch_pc_q;
    assign out_valid = ~fifo_empty;
    assign out_instr = head[ADDRESS_WIDTH +: DATA_WIDTH];
    assign out_pc    = head[ADDRESS_WIDTH-1:0];
    assign pop       = out_valid & out_ready;

    always_comb begin
        push       = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            // Redirect wins over everything; only BOOT is forced onward.
            fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            if (state_q == BOOT) begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (!fifo_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .Width(EntryWidth)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .wdata({RD, fetch_pc_q}),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of the fetch address and PCs.
REQ-002 Parameter DATA_WIDTH, default 32, width of the instruction word.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port A  output  ADDRESS_WIDTH  byte address to instruction memory; memory returns RD combinationally in the same cycle.
REQ-007 Port RD  input  DATA_WIDTH  instruction word read at A.
REQ-008 Port halt  input  1  request to stop issuing new fetches.
REQ-009 Port redirect_valid  input  1  branch/jump redirect strobe.
REQ-010 Port redirect_pc  input  ADDRESS_WIDTH  redirect target.
REQ-011 Port out_valid  output  1  out_instr/out_pc hold a valid instruction.
REQ-012 Port out_ready  input  1  consumer accepts the instruction this cycle.
REQ-013 Port out_instr  output  DATA_WIDTH  fetched instruction.
REQ-014 Port out_pc  output  ADDRESS_WIDTH  address of out_instr.

Function
REQ-015 fetch_pc register SHALL drive A directly; A SHALL have bits [1:0] always zero.
REQ-016 FSM states SHALL be BOOT, RUN, HALTED.
REQ-017 BOOT: entered on reset; no capture; next state RUN unconditionally.
REQ-018 RUN: when the buffer has space or a pop occurs this cycle, {RD, fetch_pc} SHALL be pushed and fetch_pc SHALL advance by 4; otherwise fetch_pc holds.
REQ-019 RUN -> HALTED when halt=1 (no push in that cycle); HALTED -> RUN when halt=0.
REQ-020 HALTED: no pushes; buffered entries still drain via out_ready.
REQ-021 Instruction buffer: 2-entry FIFO of {instr, pc}; out_valid = not empty; head drives out_instr/out_pc.
REQ-022 Pop occurs when out_valid and out_ready are both 1; push and pop in the same cycle with buffer full SHALL be allowed, with occupancy unchanged.
REQ-023 out_instr/out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 redirect_valid=1 SHALL take priority over push, pop, halt and state: flush the buffer, set fetch_pc to {redirect_pc[ADDRESS_WIDTH-1:2],2'b00}, and leave the state unchanged except BOOT -> RUN.
REQ-025 After a redirect, out_valid SHALL be 0 in the following cycle; the first instruction from the target SHALL appear one cycle after that.
REQ-026 A pop coinciding with a redirect SHALL be treated as accepted by the consumer; the buffer is still flushed.
REQ-027 fetch_pc addition SHALL wrap modulo 2^ADDRESS_WIDTH with no flag.
REQ-028 Steady-state throughput SHALL be one instruction per cycle with out_ready held high; latency from A to out_valid is one cycle.

Reset
REQ-029 While rst_n=0: state=BOOT, fetch_pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0.
REQ-030 Reset assertion mid-operation SHALL discard buffered instructions immediately, asynchronously to clk.
REQ-031 First out_valid=1 SHALL occur no earlier than the second rising edge after rst_n deasserts (BOOT, then capture).

Structure
REQ-032 Package fetch_pkg SHALL hold the fetch_state_t enum (BOOT, RUN, HALTED), INSTR_BYTES=4 and the default RESET_PC.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (2 entries, parameterised width, push/pop/flush, full/empty).
REQ-034 The block SHALL have no combinational path from RD to any output.

Verification
REQ-035 Reset release, memory with bytes 00..FF at addresses 0..FF, out_ready=1 -> A=0,0,4,8...; out_pc sequence 0,4,8 with out_instr 32'h00010203, 32'h04050607, 32'h08090A0B.
REQ-036 out_ready=0 for 5 cycles after the first valid -> buffer fills at 2; A holds at 8; out_pc stays 0; on release, out_pc=0,4,8 with no gaps or duplicates.
REQ-037 redirect_valid=1, redirect_pc=32'h43 while full -> next cycle out_valid=0, A=32'h40; following cycle out_pc=32'h40, out_instr=32'h40414243.
REQ-038 halt=1 for 4 cycles with out_ready=1 -> buffered entries drain, then out_valid=0, A frozen; halt=0 resumes at the frozen A.
REQ-039 fetch_pc=32'hFFFF_FFFC, run two cycles -> out_pc=32'hFFFF_FFFC then 32'h0000_0000.
REQ-040 rst_n pulsed low mid-stream between clock edges -> out_valid=0 immediately; after release, out_pc restarts at RESET_PC.
